// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control_if
// Description : Bundle between the multicycle MIPS control FSM and its
//               datapath. Carries the opcode and memory-ready handshake
//               into the controller, and all datapath selects, write
//               enables, status pulses and the debug state back out.
//               master : control FSM side (drives the controls)
//               slave  : datapath side (drives Op and mem_ready)
// Revision    : 1.0  initial release
// ============================================================================
interface mips_multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Op;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               IRWrite;
    logic [1:0]         PCSource;
    logic [1:0]         ALUOp;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               RegWrite;
    logic               RegDst;
    logic               illegal_op;
    logic               mem_timeout;
    logic [STATE_W-1:0] state;

    modport master (
        input  Op, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, illegal_op, mem_timeout, state
    );

    modport slave (
        output Op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, illegal_op, mem_timeout, state
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control
// Description : Main control FSM for the multicycle MIPS datapath. Steps
//               fetch / decode / execute / memory / writeback from the IR
//               opcode and stalls on a single-port memory ready handshake,
//               optionally aborting after WAIT_LIMIT not-ready cycles.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - master modport: Op/mem_ready in; mux selects,
//                        write enables, ALUOp, illegal_op, mem_timeout and
//                        debug state out
// Parameters  : WAIT_LIMIT - max consecutive not-ready memory cycles before
//                            abort (0 = wait forever)
//               STATE_W    - width of the state encoding / debug port
// Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle_control #(
    parameter int WAIT_LIMIT = 0,
    parameter int STATE_W    = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    mips_multicycle_control_if.master   bus
);

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = STATE_W'(0),
        ST_DECODE   = STATE_W'(1),
        ST_MEMADR   = STATE_W'(2),
        ST_MEMRD    = STATE_W'(3),
        ST_MEMWB    = STATE_W'(4),
        ST_MEMWR    = STATE_W'(5),
        ST_EXEC     = STATE_W'(6),
        ST_ALUWB    = STATE_W'(7),
        ST_BRANCH   = STATE_W'(8),
        ST_JUMP     = STATE_W'(9),
        ST_ADDIEXEC = STATE_W'(10),
        ST_ADDIWB   = STATE_W'(11),
        ST_TRAP     = STATE_W'(12)
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    // Counter only needs to reach WAIT_LIMIT-1.
    localparam int              CNT_W        = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic            c_timeout_en = (WAIT_LIMIT > 0);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'((WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_timeout;

    state_t             w_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_abort;
    logic               w_mem_state;

    // ------------------------------------------------------------------
    // Next-state and wait-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = '0;
        w_abort     = 1'b0;
        w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                      (r_state == ST_MEMWR);

        case (r_state)
            ST_FETCH:    if (bus.mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                case (bus.Op)
                    c_op_lw, c_op_sw: w_next = ST_MEMADR;
                    c_op_rtype:       w_next = ST_EXEC;
                    c_op_beq:         w_next = ST_BRANCH;
                    c_op_j:           w_next = ST_JUMP;
                    c_op_addi:        w_next = ST_ADDIEXEC;
                    default:          w_next = ST_TRAP;
                endcase
            end
            // Only lw/sw reach here, so anything that is not lw is a store.
            ST_MEMADR:   w_next = (bus.Op == c_op_lw) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:    if (bus.mem_ready) w_next = ST_MEMWB;
            ST_MEMWB:    w_next = ST_FETCH;
            ST_MEMWR:    if (bus.mem_ready) w_next = ST_FETCH;
            ST_EXEC:     w_next = ST_ALUWB;
            ST_ALUWB:    w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_ADDIEXEC: w_next = ST_ADDIWB;
            ST_ADDIWB:   w_next = ST_FETCH;
            ST_TRAP:     w_next = ST_FETCH;
            default:     w_next = ST_FETCH;
        endcase

        // A stalled memory state never changes state on its own, so the
        // counter only advances while sitting in one; every other path
        // (ready, state change) leaves it at the cleared default.
        if (c_timeout_en && w_mem_state && !bus.mem_ready) begin
            if (r_cnt == c_cnt_last) begin
                w_abort = 1'b1;
                w_next  = ST_FETCH;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_cnt         <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_mem_timeout <= w_abort;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except the FETCH-cycle IR/PC loads which wait
    // for the instruction word to actually arrive)
    // ------------------------------------------------------------------
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.illegal_op  = 1'b0;

        case (r_state)
            ST_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            ST_DECODE: begin
                bus.ALUSrcB = 2'b11;
            end
            ST_MEMADR, ST_ADDIEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ST_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            ST_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            ST_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            ST_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            ST_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            ST_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            ST_ADDIWB: begin
                bus.RegWrite = 1'b1;
            end
            ST_TRAP: begin
                bus.illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_timeout = r_mem_timeout;
    assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Self-checking bench for mips_multicycle_control. One DUT with
//               WAIT_LIMIT=0 and one with WAIT_LIMIT=4, driven with the same
//               Op/mem_ready, checked against hand-written vector tables.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_control;

    logic clk;
    logic rst_n;

    mips_multicycle_control_if #(.STATE_W(4)) if0 ();
    mips_multicycle_control_if #(.STATE_W(4)) if4 ();

    mips_multicycle_control #(.WAIT_LIMIT(0), .STATE_W(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    mips_multicycle_control #(.WAIT_LIMIT(4), .STATE_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word, MSB first:
    // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
    // PCSource[1:0] ALUOp[1:0] ALUSrcA ALUSrcB[1:0] RegWrite RegDst illegal_op
    logic [16:0] act0, act4;
    assign act0 = {if0.PCWrite, if0.PCWriteCond, if0.IorD, if0.MemRead, if0.MemWrite,
                   if0.MemtoReg, if0.IRWrite, if0.PCSource, if0.ALUOp, if0.ALUSrcA,
                   if0.ALUSrcB, if0.RegWrite, if0.RegDst, if0.illegal_op};
    assign act4 = {if4.PCWrite, if4.PCWriteCond, if4.IorD, if4.MemRead, if4.MemWrite,
                   if4.MemtoReg, if4.IRWrite, if4.PCSource, if4.ALUOp, if4.ALUSrcA,
                   if4.ALUSrcB, if4.RegWrite, if4.RegDst, if4.illegal_op};

    //                              PW PWC IoD MR MW M2R IRW PCS    OP     A  B     RW RD IL
    localparam logic [16:0] c_fr  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_fw  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_dec = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_ma  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_mr  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_mwb = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b0};
    localparam logic [16:0] c_mw  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_ex  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,2'b00,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_awb = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b1,1'b0};
    localparam logic [16:0] c_br  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b1,2'b00,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_jmp = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_ie  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0};
    localparam logic [16:0] c_iwb = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b0};
    localparam logic [16:0] c_trp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b1};

    localparam logic [5:0] c_r    = 6'b000000;
    localparam logic [5:0] c_lw   = 6'b100011;
    localparam logic [5:0] c_sw   = 6'b101011;
    localparam logic [5:0] c_beq  = 6'b000100;
    localparam logic [5:0] c_j    = 6'b000010;
    localparam logic [5:0] c_addi = 6'b001000;
    localparam logic [5:0] c_bad  = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic        to;
    } vec_t;

    vec_t tbl0[$];
    vec_t tbl4[$];

    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                                input logic [16:0] ctrl, input logic to);
        vec_t v;
        v.op   = op;
        v.rdy  = rdy;
        v.st   = st;
        v.ctrl = ctrl;
        v.to   = to;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic rdy);
        if0.Op        = op;
        if0.mem_ready = rdy;
        if4.Op        = op;
        if4.mem_ready = rdy;
    endtask

    task automatic check_dut(input int sel, input string tag, input logic [3:0] st,
                             input logic [16:0] ctrl, input logic to);
        if (sel == 0) begin
            check({tag, " state"}, 32'(if0.state), 32'(st));
            check({tag, " ctrl"},  32'(act0),      32'(ctrl));
            check({tag, " mem_timeout"}, 32'(if0.mem_timeout), 32'(to));
        end else begin
            check({tag, " state"}, 32'(if4.state), 32'(st));
            check({tag, " ctrl"},  32'(act4),      32'(ctrl));
            check({tag, " mem_timeout"}, 32'(if4.mem_timeout), 32'(to));
        end
    endtask

    // Apply one vector in the low phase, check mid-phase, let the next
    // rising edge advance the FSM.
    task automatic run_vec(input int sel, input vec_t v, input int idx);
        @(negedge clk);
        drive(v.op, v.rdy);
        #1;
        check_dut(sel, $sformatf("t%0d[%0d]", sel, idx), v.st, v.ctrl, v.to);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(c_r, 1'b0);
        rst_n = 1'b0;
        #1;
        check_dut(0, "reset dut0", 4'd0, c_fw, 1'b0);
        check_dut(4, "reset dut4", 4'd0, c_fw, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(c_r, 1'b0);

        // ---- WAIT_LIMIT=0 table ----
        // R-type: 0,1,6,7,0
        tbl0.push_back(mk(c_r, 1, 4'd0, c_fr, 0));
        tbl0.push_back(mk(c_r, 1, 4'd1, c_dec, 0));
        tbl0.push_back(mk(c_r, 1, 4'd6, c_ex, 0));
        tbl0.push_back(mk(c_r, 1, 4'd7, c_awb, 0));
        // lw with a one-cycle fetch stall and three MEMRD stalls
        tbl0.push_back(mk(c_lw, 0, 4'd0, c_fw, 0));
        tbl0.push_back(mk(c_lw, 1, 4'd0, c_fr, 0));
        tbl0.push_back(mk(c_lw, 1, 4'd1, c_dec, 0));
        tbl0.push_back(mk(c_lw, 1, 4'd2, c_ma, 0));
        for (int i = 0; i < 3; i++) tbl0.push_back(mk(c_lw, 0, 4'd3, c_mr, 0));
        tbl0.push_back(mk(c_lw, 1, 4'd3, c_mr, 0));
        tbl0.push_back(mk(c_lw, 1, 4'd4, c_mwb, 0));
        // sw with a long stall: no timeout when WAIT_LIMIT=0
        tbl0.push_back(mk(c_sw, 1, 4'd0, c_fr, 0));
        tbl0.push_back(mk(c_sw, 1, 4'd1, c_dec, 0));
        tbl0.push_back(mk(c_sw, 1, 4'd2, c_ma, 0));
        for (int i = 0; i < 6; i++) tbl0.push_back(mk(c_sw, 0, 4'd5, c_mw, 0));
        tbl0.push_back(mk(c_sw, 1, 4'd5, c_mw, 0));
        // beq
        tbl0.push_back(mk(c_beq, 1, 4'd0, c_fr, 0));
        tbl0.push_back(mk(c_beq, 1, 4'd1, c_dec, 0));
        tbl0.push_back(mk(c_beq, 1, 4'd8, c_br, 0));
        // j
        tbl0.push_back(mk(c_j, 1, 4'd0, c_fr, 0));
        tbl0.push_back(mk(c_j, 1, 4'd1, c_dec, 0));
        tbl0.push_back(mk(c_j, 1, 4'd9, c_jmp, 0));
        // addi
        tbl0.push_back(mk(c_addi, 1, 4'd0, c_fr, 0));
        tbl0.push_back(mk(c_addi, 1, 4'd1, c_dec, 0));
        tbl0.push_back(mk(c_addi, 1, 4'd10, c_ie, 0));
        tbl0.push_back(mk(c_addi, 1, 4'd11, c_iwb, 0));
        // illegal opcode: TRAP for exactly one cycle
        tbl0.push_back(mk(c_bad, 1, 4'd0, c_fr, 0));
        tbl0.push_back(mk(c_bad, 1, 4'd1, c_dec, 0));
        tbl0.push_back(mk(c_bad, 1, 4'd12, c_trp, 0));
        tbl0.push_back(mk(c_r, 0, 4'd0, c_fw, 0));

        // ---- WAIT_LIMIT=4 table ----
        // sw aborted after 4 not-ready MEMWR cycles
        tbl4.push_back(mk(c_sw, 1, 4'd0, c_fr, 0));
        tbl4.push_back(mk(c_sw, 1, 4'd1, c_dec, 0));
        tbl4.push_back(mk(c_sw, 1, 4'd2, c_ma, 0));
        for (int i = 0; i < 4; i++) tbl4.push_back(mk(c_sw, 0, 4'd5, c_mw, 0));
        tbl4.push_back(mk(c_sw, 0, 4'd0, c_fw, 1));
        tbl4.push_back(mk(c_sw, 1, 4'd0, c_fr, 0));
        // sw with ready arriving in the limit cycle: normal completion
        tbl4.push_back(mk(c_sw, 1, 4'd1, c_dec, 0));
        tbl4.push_back(mk(c_sw, 1, 4'd2, c_ma, 0));
        for (int i = 0; i < 3; i++) tbl4.push_back(mk(c_sw, 0, 4'd5, c_mw, 0));
        tbl4.push_back(mk(c_sw, 1, 4'd5, c_mw, 0));
        // aborted FETCH re-enters FETCH with a fresh count
        for (int i = 0; i < 4; i++) tbl4.push_back(mk(c_r, 0, 4'd0, c_fw, 0));
        tbl4.push_back(mk(c_r, 0, 4'd0, c_fw, 1));
        tbl4.push_back(mk(c_r, 1, 4'd0, c_fr, 0));
        tbl4.push_back(mk(c_r, 1, 4'd1, c_dec, 0));

        // Reset state
        #2;
        check_dut(0, "por dut0", 4'd0, c_fw, 1'b0);
        check_dut(4, "por dut4", 4'd0, c_fw, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl0[i]) run_vec(0, tbl0[i], i);

        // Reset mid-EXEC: immediate return to FETCH, no write enables
        run_vec(0, mk(c_r, 1, 4'd0, c_fr, 0), 100);
        run_vec(0, mk(c_r, 1, 4'd1, c_dec, 0), 101);
        run_vec(0, mk(c_r, 0, 4'd6, c_ex, 0), 102);
        rst_n = 1'b0;
        #1;
        check_dut(0, "async reset", 4'd0, c_fw, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, mk(c_r, 0, 4'd0, c_fw, 0), 103);

        do_reset();
        foreach (tbl4[i]) run_vec(4, tbl4[i], i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback steps from the IR opcode. It drives all datapath mux selects and write enables, plus the 2-bit ALUOp consumed by ALUControl. It stalls on a single-port memory ready handshake, with an optional timeout.

Parameters:
WAIT_LIMIT, 0, max consecutive not-ready cycles in a memory state before abort; 0 = wait forever
STATE_W, 4, width of the state encoding / state debug port

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Op  input  6  opcode, IR[31:26]; stable except after IRWrite
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
IRWrite  output  1  IR load
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  output  2  to ALUControl: 00 add, 01 sub, 10 funct
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
RegWrite  output  1  register file write
RegDst  output  1  0=rt, 1=rd
illegal_op  output  1  high for one cycle in TRAP
mem_timeout  output  1  registered one-cycle pulse after a timeout abort
state  output  STATE_W  current state, for debug

Behaviour:
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEXEC=10, ADDIWB=11, TRAP=12. Codes 13-15 go to FETCH on the next clock.
- Reset (async, rst_n=0): state=FETCH, wait counter=0, mem_timeout=0. Outputs immediately take the FETCH decode values.
- All outputs are combinational from state, except IRWrite and PCWrite in FETCH, which also depend on mem_ready. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEXEC
  - otherwise -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. On mem_ready -> MEMWB, else stay.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. On mem_ready -> FETCH, else stay.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- TRAP: illegal_op=1. Next FETCH; the PC has already advanced, so the bad instruction is skipped.
- Latencies from the FETCH cycle with mem_ready=1, zero wait states:
  - R-type/addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/j: 3 cycles
- Wait counter (WAIT_LIMIT>0 only):
  - Counts cycles spent in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When the counter = WAIT_LIMIT-1 and mem_ready=0: next state = FETCH, counter clears, mem_timeout=1 for the following cycle only. No register or PC write occurs for the aborted instruction.
  - Aborted FETCH re-enters FETCH with counter=0.
  - mem_ready=1 in the limit cycle wins: normal transition, no timeout.
- WAIT_LIMIT=0: counter held at 0, mem_timeout never asserts.
- Reset mid-instruction: immediate return to FETCH, no pending writes asserted.

Test Plan:
- Reset with rst_n=0 mid-EXEC, then release -> state=0, MemRead=1, ALUSrcB=01, RegWrite=0, mem_timeout=0.
- mem_ready tied 1, Op=000000 -> states 0,1,6,7,0. ALUOp=10 in EXEC; RegWrite=1 and RegDst=1 in ALUWB.
- Op=100011, mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. IorD=1 throughout MEMRD; MemtoReg=1 in MEMWB.
- Op=000100 then Op=000010 -> BRANCH: PCWriteCond=1, PCSource=01, ALUOp=01. JUMP: PCWrite=1, PCSource=10. Both return to FETCH after 1 cycle.
- Op=111111 -> DECODE then TRAP, with illegal_op=1 for exactly 1 cycle, then FETCH.
- WAIT_LIMIT=4, Op=101011, mem_ready=0 in MEMWR -> 4 cycles in MEMWR, then FETCH, mem_timeout=1 for one cycle, MemWrite=0 after abort. Repeat with mem_ready=1 in the 4th cycle -> normal return to FETCH, no mem_timeout.
